// File: rtl/reg_file_mp.sv
// Multi-port register file with two synchronous write ports, same-cycle bypass on reads,
// and a sequencer that zeroes one entry per cycle after reset or on request.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    output logic                     ready,
    output logic                     wcollide
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   clr_cnt_r, clr_cnt_s;
    logic                ready_r, ready_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                commit_s;
    logic                wr0_s, wr1_s;

    // Entry 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG == 0) || (addr != '0);
    endfunction

    // A write (and therefore a bypass) only happens when it will actually commit.
    assign commit_s = (state_r == ST_READY) && !clear_req;
    assign wr0_s    = commit_s && we0 && addr_writable(waddr0);
    assign wr1_s    = commit_s && we1 && addr_writable(waddr1);
    assign wcollide = we0 && we1 && (waddr0 == waddr1) && addr_writable(waddr0);
    assign ready    = ready_r;

    // FSM state, clear counter and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
            ready_r   <= ready_s;
        end
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        ready_s   = ready_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_IDX) begin
                    state_s   = ST_READY;
                    clr_cnt_s = '0;
                    ready_s   = 1'b1;
                end else begin
                    clr_cnt_s = clr_cnt_r + 1'b1;
                    ready_s   = 1'b0;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_s   = ST_CLEAR;
                    clr_cnt_s = '0;
                    ready_s   = 1'b0;
                end else begin
                    ready_s   = 1'b1;
                end
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_cnt_s = '0;
                ready_s   = 1'b0;
            end
        endcase
    end

    // Storage: clear one entry per cycle, otherwise commit writes (port 1 ordered last so it wins).
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else begin
            if (wr0_s) begin
                mem_r[waddr0] <= wdata0;
            end
            if (wr1_s) begin
                mem_r[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[k*ADDR_W +: ADDR_W];

        // Per-port read mux with bypass from the in-flight writes.
        always_comb begin
            rd_s = '0;
            if (state_r == ST_CLEAR) begin
                rd_s = '0;
            end else if ((ZERO_REG != 0) && (ra_s == '0)) begin
                rd_s = '0;
            end else if (commit_s && we1 && (waddr1 == ra_s)) begin
                rd_s = wdata1;
            end else if (commit_s && we0 && (waddr0 == ra_s)) begin
                rd_s = wdata0;
            end else begin
                rd_s = mem_r[ra_s];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_s;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default configuration plus a
// small 4-read-port, 8-entry, ZERO_REG=0 instance.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Instance A: defaults (DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1)
    logic        rst, clear_req, we0, we1, ready, wcollide;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;

    // Instance B: ADDR_W=3, NUM_RD=4, ZERO_REG=0
    logic         rst_b, clear_req_b, we0_b, we1_b, ready_b, wcollide_b;
    logic [11:0]  raddr_b;
    logic [127:0] rdata_b;
    logic [2:0]   waddr0_b, waddr1_b;
    logic [31:0]  wdata0_b, wdata1_b;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .raddr(raddr), .rdata(rdata),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .ready(ready), .wcollide(wcollide)
    );

    reg_file_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst_b), .clear_req(clear_req_b), .raddr(raddr_b), .rdata(rdata_b),
        .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
        .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
        .ready(ready_b), .wcollide(wcollide_b)
    );

    task automatic idle_a();
        clear_req = 1'b0;
        we0 = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
        we1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        raddr = {5'd9, 5'd5};
        #1;
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", ready); end
        n_tests++;
        if (rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        rst = 1'b0;
        rst_b = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ready !== (i == 32)) begin
                n_fail++; $display("FAIL reset_clear_len cycle %0d got %b exp %b", i, ready, (i == 32));
            end
        end
        n_tests++;
        if (rdata !== 64'h0) begin n_fail++; $display("FAIL post_clear_rdata got %h exp 0", rdata); end
        // asynchronous assertion between clock edges
        rst = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready got %b exp 0", ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_reclear got %b exp 1", ready); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        raddr = {5'd6, 5'd5};
        #1;
        n_tests++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bypass got %h exp deadbeef", rdata[31:0]); end
        n_tests++;
        if (rdata[63:32] !== 32'h0) begin n_fail++; $display("FAIL wr_other_port got %h exp 0", rdata[63:32]); end
        @(negedge clk);
        idle_a();
        #1;
        n_tests++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_stored got %h exp deadbeef", rdata[31:0]); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr = {5'd5, 5'd7};
        #1;
        n_tests++;
        if (wcollide !== 1'b1) begin n_fail++; $display("FAIL coll_flag got %b exp 1", wcollide); end
        n_tests++;
        if (rdata[31:0] !== 32'h22) begin n_fail++; $display("FAIL coll_bypass got %h exp 22", rdata[31:0]); end
        @(negedge clk);
        idle_a();
        #1;
        n_tests++;
        if (rdata[31:0] !== 32'h22) begin n_fail++; $display("FAIL coll_stored got %h exp 22", rdata[31:0]); end
        n_tests++;
        if (wcollide !== 1'b0) begin n_fail++; $display("FAIL coll_idle got %b exp 0", wcollide); end
        // address 0 is read-only zero
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h22;
        raddr = {5'd0, 5'd0};
        #1;
        n_tests++;
        if (wcollide !== 1'b0) begin n_fail++; $display("FAIL coll0_flag got %b exp 0", wcollide); end
        n_tests++;
        if (rdata !== 64'h0) begin n_fail++; $display("FAIL coll0_bypass got %h exp 0", rdata); end
        @(negedge clk);
        idle_a();
        #1;
        n_tests++;
        if (rdata !== 64'h0) begin n_fail++; $display("FAIL coll0_stored got %h exp 0", rdata); end
        // distinct addresses on both ports, each port bypassed independently
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'hA5A5A5A5;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h5A5A5A5A;
        raddr = {5'd9, 5'd8};
        #1;
        n_tests++;
        if (rdata !== 64'h5A5A5A5A_A5A5A5A5) begin n_fail++; $display("FAIL dual_bypass got %h exp 5a5a5a5aa5a5a5a5", rdata); end
        n_tests++;
        if (wcollide !== 1'b0) begin n_fail++; $display("FAIL dual_flag got %b exp 0", wcollide); end
        @(negedge clk);
        idle_a();
    endtask

    task automatic test_clear_req();
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'h100 + 32'(i);
        end
        @(negedge clk);
        idle_a();
        raddr = {5'd3, 5'd31};
        #1;
        n_tests++;
        if (rdata !== 64'h00000103_0000011F) begin n_fail++; $display("FAIL fill_read got %h exp 000001030000011f", rdata); end
        // clear request with a simultaneous write: no bypass, write discarded
        @(negedge clk);
        clear_req = 1'b1;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hBAD;
        #1;
        n_tests++;
        if (rdata[63:32] !== 32'h103) begin n_fail++; $display("FAIL clrreq_nobypass got %h exp 103", rdata[63:32]); end
        @(negedge clk);
        idle_a();
        // sampling posedge already happened; this is cycle 1 of the clear after the next posedge
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ready !== (i == 32)) begin
                n_fail++; $display("FAIL clrreq_len cycle %0d got %b exp %b", i, ready, (i == 32));
            end
            if (i == 1) begin
                n_tests++;
                if (rdata !== 64'h0) begin n_fail++; $display("FAIL clrreq_read_in_clear got %h exp 0", rdata); end
            end
            // a request during the clear must not restart it
            clear_req = (i == 10);
        end
        clear_req = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            n_tests++;
            if (rdata !== 64'h0) begin n_fail++; $display("FAIL clrreq_zero addr %0d got %h exp 0", a, rdata); end
        end
    endtask

    task automatic test_mid_clear_reset();
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b exp 0", ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ready !== (i == 32)) begin
                n_fail++; $display("FAIL midrst_len cycle %0d got %b exp %b", i, ready, (i == 32));
            end
        end
    endtask

    task automatic test_param_sweep();
        @(negedge clk);
        clear_req_b = 1'b1;
        @(posedge clk); #1;
        clear_req_b = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (ready_b !== (i == 8)) begin
                n_fail++; $display("FAIL sweep_len cycle %0d got %b exp %b", i, ready_b, (i == 8));
            end
        end
        @(negedge clk);
        we0_b = 1'b1; waddr0_b = 3'd0; wdata0_b = 32'hA0;
        we1_b = 1'b1; waddr1_b = 3'd5; wdata1_b = 32'h55;
        raddr_b = {3'd7, 3'd2, 3'd5, 3'd0};
        #1;
        n_tests++;
        if (rdata_b !== {32'h0, 32'h0, 32'h55, 32'hA0}) begin n_fail++; $display("FAIL sweep_bypass got %h", rdata_b); end
        @(negedge clk);
        we0_b = 1'b1; waddr0_b = 3'd2; wdata0_b = 32'h22;
        we1_b = 1'b1; waddr1_b = 3'd7; wdata1_b = 32'h77;
        @(negedge clk);
        we0_b = 1'b0; we1_b = 1'b0;
        raddr_b = {3'd0, 3'd7, 3'd2, 3'd5};
        #1;
        n_tests++;
        if (rdata_b !== {32'hA0, 32'h77, 32'h22, 32'h55}) begin n_fail++; $display("FAIL sweep_stored got %h", rdata_b); end
        @(negedge clk);
        we0_b = 1'b1; waddr0_b = 3'd0; wdata0_b = 32'h01;
        we1_b = 1'b1; waddr1_b = 3'd0; wdata1_b = 32'h02;
        #1;
        n_tests++;
        if (wcollide_b !== 1'b1) begin n_fail++; $display("FAIL sweep_coll0 got %b exp 1", wcollide_b); end
        n_tests++;
        if (rdata_b[127:96] !== 32'h02) begin n_fail++; $display("FAIL sweep_coll0_bypass got %h exp 2", rdata_b[127:96]); end
        @(negedge clk);
        we0_b = 1'b0; we1_b = 1'b0;
        #1;
        n_tests++;
        if (rdata_b[127:96] !== 32'h02) begin n_fail++; $display("FAIL sweep_coll0_stored got %h exp 2", rdata_b[127:96]); end
    endtask

    initial begin
        rst = 1'b1;
        raddr = 10'd0;
        idle_a();
        rst_b = 1'b1;
        clear_req_b = 1'b0;
        raddr_b = 12'd0;
        we0_b = 1'b0; waddr0_b = 3'd0; wdata0_b = 32'h0;
        we1_b = 1'b0; waddr1_b = 3'd0; wdata1_b = 32'h0;

        test_reset();
        test_write_read();
        test_collision();
        test_clear_req();
        test_mid_clear_reset();
        test_param_sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
